// File: rtl/sector_prefetch.sv
// Sector prefetcher: reads the sector after the one under the head from buffer RAM
// and streams it as {tdata, tlast, tid} through a 2-entry skid FIFO.
module sector_prefetch #(
    parameter int ADDR_WIDTH   = 16,
    parameter int SECTOR_BYTES = 512
) (
    input  logic                  csr_aclk,
    input  logic                  csr_aresetn,
    input  logic                  enable,
    input  logic [7:0]            sectors_per_track,
    input  logic [7:0]            sector_number,
    input  logic [ADDR_WIDTH-1:0] track_base,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  parallel_tvalid,
    input  logic                  parallel_tready,
    output logic [7:0]            parallel_tdata,
    output logic                  parallel_tlast,
    output logic [7:0]            parallel_tid,
    output logic                  busy
);

    localparam int IW = (SECTOR_BYTES > 2) ? $clog2(SECTOR_BYTES) : 1;
    localparam logic [IW-1:0]         LAST_IDX = IW'(SECTOR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] SEC_SZ   = ADDR_WIDTH'(SECTOR_BYTES);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] tid;
    } beat_t;

    state_t                  state, state_nx;
    logic [7:0]              target, target_nx;
    logic [IW-1:0]           byte_idx, byte_idx_nx;
    logic [ADDR_WIDTH-1:0]   base, base_nx;

    logic                    inflight, infl_last;
    logic [7:0]              infl_tid;

    beat_t                   fifo [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    beat_t                   head;

    logic                    pop, push, issue, last_issue, drain_done;
    logic [2:0]              occ;

    function automatic logic [7:0] next_sector(input logic [7:0] s, input logic [7:0] spt);
        return (s >= spt - 8'd1) ? 8'd0 : s + 8'd1;
    endfunction

    assign head            = fifo[rd_ptr];
    assign parallel_tvalid = (count != 2'd0);
    assign parallel_tdata  = parallel_tvalid ? head.data : 8'd0;
    assign parallel_tlast  = parallel_tvalid ? head.last : 1'b0;
    assign parallel_tid    = parallel_tvalid ? head.tid  : 8'd0;
    assign busy            = (state != IDLE);

    assign pop  = parallel_tvalid && parallel_tready;
    assign push = inflight;

    // Occupancy after this cycle's pop, so a streaming FIFO keeps one read per cycle;
    // the in-flight read is counted so the FIFO can never overflow.
    assign occ        = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue      = (state == FETCH) && enable && (occ < 3'd2);
    assign last_issue = issue && (byte_idx == LAST_IDX);
    assign drain_done = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

    assign mem_en   = issue;
    assign mem_addr = issue ? (base + ADDR_WIDTH'(target) * SEC_SZ + ADDR_WIDTH'(byte_idx))
                            : '0;

    always_comb begin
        state_nx    = state;
        target_nx   = target;
        byte_idx_nx = byte_idx;
        base_nx     = base;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sectors_per_track != 8'd0) begin
                        target_nx   = next_sector(sector_number, sectors_per_track);
                        byte_idx_nx = '0;
                        base_nx     = track_base;
                        state_nx    = FETCH;
                    end
                end
                FETCH: begin
                    if (issue) begin
                        byte_idx_nx = byte_idx + IW'(1);
                        if (last_issue) state_nx = DRAIN;
                    end
                end
                DRAIN: begin
                    // Hand over to the next sector as the tlast beat leaves the FIFO.
                    if (drain_done) begin
                        if (sectors_per_track == 8'd0) begin
                            state_nx = IDLE;
                        end else begin
                            target_nx   = next_sector(target, sectors_per_track);
                            byte_idx_nx = '0;
                            state_nx    = FETCH;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            state    <= IDLE;
            target   <= 8'd0;
            byte_idx <= '0;
            base     <= '0;
        end else begin
            state    <= state_nx;
            target   <= target_nx;
            byte_idx <= byte_idx_nx;
            base     <= base_nx;
        end
    end

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            inflight  <= 1'b0;
            infl_last <= 1'b0;
            infl_tid  <= 8'd0;
        end else if (!enable) begin
            // Abort: drop queued beats and ignore the data of any read in flight.
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            inflight  <= 1'b0;
            infl_last <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{data: mem_rdata, last: infl_last, tid: infl_tid};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count     <= count + 2'(push) - 2'(pop);
            inflight  <= issue;
            infl_last <= last_issue;
            infl_tid  <= target;
        end
    end

endmodule

// File: tb/tb_sector_prefetch.sv
// Bench for sector_prefetch: first-beat vector table, then stream scenarios checked
// beat by beat against a sector/byte reference model over a RAM array.
module tb_sector_prefetch;

    localparam int SB = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  spt = 8'd0;
    logic [7:0]  sn = 8'd0;
    logic [15:0] tbase = 16'h1234;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic        tvalid;
    logic        tready = 1'b0;
    logic [7:0]  tdata;
    logic        tlast;
    logic [7:0]  tid;
    logic        busy;

    sector_prefetch #(.ADDR_WIDTH(16), .SECTOR_BYTES(SB)) dut (
        .csr_aclk(clk), .csr_aresetn(rst_n), .enable(enable),
        .sectors_per_track(spt), .sector_number(sn), .track_base(tbase),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .parallel_tvalid(tvalid), .parallel_tready(tready), .parallel_tdata(tdata),
        .parallel_tlast(tlast), .parallel_tid(tid), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:65535];
    always @(posedge clk) if (mem_en) mem_rdata <= ram[mem_addr];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int spt;
        int sn;
        int base;
        int exp_tid;
        int exp_lat;
    } vec_t;
    vec_t vecs [8];

    // reference model state
    int          m_tid, m_idx, m_spt, m_base, m_beats;
    bit          m_run;
    int          maxgap, last_beat, cyc_n, men, rmode;
    bit          held;
    logic [16:0] held_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int nxt(input int s, input int n);
        return (s >= n - 1) ? 0 : s + 1;
    endfunction

    function automatic int addr_of(input int b, input int t, input int i);
        return (b + t * SB + i) & 'hFFFF;
    endfunction

    task automatic m_start(input int n, input int s, input int b);
        m_spt = n; m_tid = nxt(s, n); m_idx = 0; m_base = b;
        m_beats = 0; maxgap = 0; m_run = 1; held = 0;
    endtask

    // One clock: pick tready, check protocol and any accepted beat, advance.
    task automatic cyc();
        int a;
        case (rmode)
            0:       tready = 1'b1;
            1:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
        if (held && enable) begin
            chk("hold_valid", tvalid, 1);
            if (tvalid) chk("hold_data", {tdata, tlast, tid}, held_val);
        end
        if (tvalid && tready) begin
            if (!m_run) begin
                chk("spurious_beat", tvalid, 0);
            end else begin
                a = addr_of(m_base, m_tid, m_idx);
                chk("beat", {tdata, tlast, tid}, {ram[a], (m_idx == SB - 1), 8'(m_tid)});
                if (m_beats > 0 && cyc_n - last_beat - 1 > maxgap) maxgap = cyc_n - last_beat - 1;
                last_beat = cyc_n;
                m_beats++;
                m_idx++;
                if (m_idx == SB) begin
                    m_idx = 0;
                    m_tid = nxt(m_tid, m_spt);
                end
            end
        end
        held     = tvalid && !tready;
        held_val = {tdata, tlast, tid};
        if (mem_en) men++;
        cyc_n++;
        @(posedge clk); #1;
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        int n = 0;
        while (m_beats < target && n < budget) begin
            cyc();
            n++;
        end
        chk({name, "_timeout"}, (m_beats >= target), 1);
    endtask

    task automatic quiesce();
        enable = 1'b0; tready = 1'b0; m_run = 0; held = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        vecs[0] = '{17,   5, 'h1000,  6, 3};
        vecs[1] = '{17,  16, 'h1000,  0, 3};
        vecs[2] = '{ 1,   0, 'h0200,  0, 3};
        vecs[3] = '{ 1,   7, 'h0300,  0, 3};
        vecs[4] = '{200, 250, 'h8000, 0, 3};
        vecs[5] = '{255,  3, 'hFF00,  4, 3};
        vecs[6] = '{ 3,   1, 'h0040,  2, 3};
        vecs[7] = '{ 8, 254, 'h2000,  0, 3};
        rmode = 0; cyc_n = 0; men = 0; m_run = 0; held = 0;

        #1;
        chk("reset_outputs", {mem_en, mem_addr, tvalid, tdata, tlast, tid, busy}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("idle_after_reset", {busy, mem_en, tvalid}, 0);

        // first beat of a fresh start: latency, sector selection, address wrap
        foreach (vecs[k]) begin
            quiesce();
            spt = 8'(vecs[k].spt); sn = 8'(vecs[k].sn); tbase = 16'(vecs[k].base);
            enable = 1'b1;
            lat = 0;
            while (!tvalid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("vec_latency", lat, vecs[k].exp_lat);
            chk("vec_first_beat", {tdata, tlast, tid},
                {ram[addr_of(vecs[k].base, vecs[k].exp_tid, 0)], 1'b0, 8'(vecs[k].exp_tid)});
            chk("vec_busy", busy, 1);
            quiesce();
            chk("vec_abort", {tvalid, busy}, 0);
        end

        // sector 6 streaming, 100-cycle stall with ignored input changes, random tready
        spt = 8'd17; sn = 8'd5; tbase = 16'h1000;
        m_start(17, 5, 'h1000);
        enable = 1'b1; rmode = 0;
        run_until(256, 600, "stream_a");
        rmode = 2; men = 0;
        sn = 8'd12; tbase = 16'h3000;
        repeat (100) cyc();
        chk("stall_mem_en", (men <= 2), 1);
        rmode = 1;
        run_until(3 * SB, 9000, "random_a");
        chk("tid_sequence_end", m_tid, 9);
        rmode = 0;
        quiesce();

        // wrap to sector 0, then sector 1 with a short boundary gap
        spt = 8'd17; sn = 8'd16; tbase = 16'h1000;
        m_start(17, 16, 'h1000);
        enable = 1'b1;
        run_until(2 * SB, 3000, "wrap");
        chk("boundary_gap", (maxgap <= 3), 1);
        quiesce();

        // abort after beat 200, then restart from sector_number 9
        spt = 8'd17; sn = 8'd2; tbase = 16'h4000;
        m_start(17, 2, 'h4000);
        enable = 1'b1;
        run_until(200, 600, "abort_run");
        tready = 1'b0; enable = 1'b0;
        #1 chk("abort_mem_en", mem_en, 0);
        @(posedge clk); #1;
        chk("abort_tvalid", tvalid, 0);
        chk("abort_busy", busy, 0);
        m_run = 0; held = 0;
        repeat (5) cyc();
        sn = 8'd9;
        m_start(17, 9, 'h4000);
        enable = 1'b1;
        run_until(20, 100, "reenable");
        quiesce();

        // sectors_per_track -> 0 mid-sector: finish the sector, then idle
        spt = 8'd3; sn = 8'd0; tbase = 16'h6000;
        m_start(3, 0, 'h6000);
        enable = 1'b1;
        run_until(100, 300, "spt0_run");
        spt = 8'd0;
        n = 0;
        while (busy && n < 2000) begin
            cyc();
            n++;
        end
        chk("spt0_idle", busy, 0);
        chk("spt0_beats", m_beats, SB);
        m_run = 0; men = 0;
        repeat (10) cyc();
        chk("spt0_no_more_reads", men, 0);

        // spt=0 from a fresh enable: stays idle
        quiesce();
        enable = 1'b1; men = 0;
        repeat (20) cyc();
        chk("spt0_start_mem_en", men, 0);
        chk("spt0_start_busy", busy, 0);
        quiesce();

        // async reset mid-sector
        spt = 8'd17; sn = 8'd5; tbase = 16'h1000;
        m_start(17, 5, 'h1000);
        enable = 1'b1;
        run_until(50, 200, "reset_run");
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {mem_en, mem_addr, tvalid, tdata, tlast, tid, busy}, 0);
        enable = 1'b0; m_run = 0; held = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", {busy, tvalid, mem_en}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
